// File: rtl/vx_fpu_dispatch_rr.sv
// vx_fpu_dispatch_rr: credit-limited request fan-out to N units with round-robin response collection
module vx_fpu_dispatch_rr #(
  parameter int NUM_UNITS   = 5,
  parameter int REQW        = 96,
  parameter int RSPW        = 37,
  parameter int TAGW        = 4,
  parameter int MAX_PENDING = 4,
  parameter int SELW        = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1,
  parameter int CNTW        = $clog2(MAX_PENDING + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [SELW-1:0]           sel_in,
  input  logic [TAGW-1:0]           tag_in,
  input  logic [REQW-1:0]           req_data_in,
  output logic [NUM_UNITS-1:0]      unit_req_valid,
  input  logic [NUM_UNITS-1:0]      unit_req_ready,
  output logic [REQW-1:0]           unit_req_data,
  output logic [TAGW-1:0]           unit_req_tag,
  input  logic [NUM_UNITS-1:0]      unit_rsp_valid,
  output logic [NUM_UNITS-1:0]      unit_rsp_ready,
  input  logic [NUM_UNITS*RSPW-1:0] unit_rsp_data,
  input  logic [NUM_UNITS*TAGW-1:0] unit_rsp_tag,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [RSPW-1:0]           data_out,
  output logic [TAGW-1:0]           tag_out,
  output logic [SELW-1:0]           unit_out,
  output logic                      sel_err,
  output logic                      idle
);
  logic [CNTW-1:0] cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0] cnt_ok, busy, req_fire, dec;
  logic [SELW-1:0] rr, grant;
  logic sel_ok, has_rsp, load_en, pop;
  int idx;

  assign sel_ok = 32'(sel_in) < NUM_UNITS;
  assign ready_in = sel_ok ? (unit_req_ready[sel_in] && cnt_ok[sel_in]) : 1'b1;
  assign unit_req_data = req_data_in;
  assign unit_req_tag = tag_in;
  assign req_fire = unit_req_valid & unit_req_ready;
  assign load_en = !valid_out || ready_out;
  assign pop = has_rsp && load_en;
  assign unit_rsp_ready = pop ? (NUM_UNITS'(1) << grant) : '0;
  assign idle = ~|busy && !valid_out;

  for (genvar s = 0; s < NUM_UNITS; s++) begin : g_unit
    assign cnt_ok[s] = cnt[s] != CNTW'(MAX_PENDING);
    assign busy[s] = |cnt[s];
    assign unit_req_valid[s] = valid_in && sel_in == SELW'(s) && cnt_ok[s];
    assign dec[s] = unit_rsp_ready[s] && busy[s];
    always_ff @(posedge clk) begin
      if (reset) cnt[s] <= '0;
      else if (req_fire[s] != dec[s]) cnt[s] <= req_fire[s] ? cnt[s] + CNTW'(1) : cnt[s] - CNTW'(1);
    end
    // a response popped from a unit with no outstanding request is a protocol error
    always_ff @(posedge clk) begin
      if (!reset && unit_rsp_ready[s]) assert (busy[s]);
    end
  end

  // scan from the highest offset down so the unit nearest rr wins
  always_comb begin
    grant = rr;
    has_rsp = 1'b0;
    idx = 0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NUM_UNITS;
      if (unit_rsp_valid[idx]) begin
        grant = SELW'(idx);
        has_rsp = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out <= '0;
      tag_out <= '0;
      unit_out <= '0;
      rr <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= valid_in && !sel_ok;
      if (pop) begin
        valid_out <= 1'b1;
        data_out <= unit_rsp_data[int'(grant)*RSPW +: RSPW];
        tag_out <= unit_rsp_tag[int'(grant)*TAGW +: TAGW];
        unit_out <= grant;
        rr <= grant == SELW'(NUM_UNITS - 1) ? '0 : grant + SELW'(1);
      end else if (ready_out) valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vx_fpu_dispatch_rr.sv
// tb_vx_fpu_dispatch_rr: directed checks of dispatch, credits, round-robin collection and backpressure
module tb_vx_fpu_dispatch_rr;
  localparam int NU = 5, REQW = 96, RSPW = 37, TAGW = 4, SELW = 3;
  logic clk = 1'b0, reset, valid_in, ready_in, ready_out, valid_out, sel_err, idle;
  logic [SELW-1:0] sel_in, unit_out;
  logic [TAGW-1:0] tag_in, unit_req_tag, tag_out;
  logic [REQW-1:0] req_data_in, unit_req_data;
  logic [NU-1:0] unit_req_valid, unit_req_ready, unit_rsp_valid, unit_rsp_ready;
  logic [NU*RSPW-1:0] unit_rsp_data;
  logic [NU*TAGW-1:0] unit_rsp_tag;
  logic [RSPW-1:0] data_out;
  int checks = 0, errors = 0;
  int fu [3] = '{0, 2, 3};

  vx_fpu_dispatch_rr dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .sel_in(sel_in),
    .tag_in(tag_in), .req_data_in(req_data_in), .unit_req_valid(unit_req_valid),
    .unit_req_ready(unit_req_ready), .unit_req_data(unit_req_data), .unit_req_tag(unit_req_tag),
    .unit_rsp_valid(unit_rsp_valid), .unit_rsp_ready(unit_rsp_ready), .unit_rsp_data(unit_rsp_data),
    .unit_rsp_tag(unit_rsp_tag), .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .tag_out(tag_out), .unit_out(unit_out), .sel_err(sel_err), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; valid_in = 0; sel_in = 0; tag_in = 0; req_data_in = 0; unit_req_ready = '1;
    unit_rsp_valid = 0; unit_rsp_data = 0; unit_rsp_tag = 0; ready_out = 1;
    tick; tick;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_idle", idle, 1);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_data_out", data_out, 0);
    reset = 0;
    #1 chk("rst_ready_in", ready_in, 1);
    // two credits each on units 0, 2, 3
    valid_in = 1;
    req_data_in = 96'h123456789;
    for (int j = 0; j < 3; j++)
      for (int r = 0; r < 2; r++) begin
        sel_in = SELW'(fu[j]);
        #1 chk("disp_valid", unit_req_valid, 64'(1) << fu[j]);
        tick;
      end
    chk("disp_data", unit_req_data, 64'h123456789);
    valid_in = 0;
    for (int i = 0; i < NU; i++) begin
      unit_rsp_data[i*RSPW +: RSPW] = RSPW'(37'h100 + i);
      unit_rsp_tag[i*TAGW +: TAGW] = TAGW'(i + 1);
    end
    unit_rsp_valid = 5'b01101;
    for (int k = 0; k < 6; k++) begin
      #1 chk("fair_grant", unit_rsp_ready, 64'(1) << fu[k % 3]);
      if (k > 0) chk("fair_unit_out", unit_out, fu[(k - 1) % 3]);
      tick;
    end
    unit_rsp_valid = 0;
    chk("fair_last_unit", unit_out, 3);
    chk("fair_last_data", data_out, 37'h103);
    chk("fair_last_tag", tag_out, 4);
    tick;
    chk("fair_drain", valid_out, 0);
    chk("fair_idle", idle, 1);
    // backpressure: tags A..D to units 0..3
    valid_in = 1;
    for (int i = 0; i < 4; i++) begin
      sel_in = SELW'(i);
      tag_in = TAGW'(10 + i);
      #1 chk("bp_req_tag", unit_req_tag, 10 + i);
      tick;
    end
    valid_in = 0;
    for (int i = 0; i < 4; i++) begin
      unit_rsp_data[i*RSPW +: RSPW] = RSPW'(37'h200 + i);
      unit_rsp_tag[i*TAGW +: TAGW] = TAGW'(10 + i);
    end
    ready_out = 0;
    unit_rsp_valid = 5'b01111;
    #1 chk("bp_first_pop", unit_rsp_ready, 5'b00001);
    tick;
    unit_rsp_valid[0] = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_stall_ready", unit_rsp_ready, 0);
      chk("bp_stall_valid", valid_out, 1);
      chk("bp_stall_tag", tag_out, 4'hA);
      chk("bp_stall_data", data_out, 37'h200);
      tick;
    end
    ready_out = 1;
    for (int i = 1; i < 4; i++) begin
      #1 chk("bp_grant", unit_rsp_ready, 64'(1) << i);
      tick;
      unit_rsp_valid[i] = 0;
      chk("bp_tag_out", tag_out, 10 + i);
      chk("bp_unit_out", unit_out, i);
    end
    tick;
    chk("bp_drain", valid_out, 0);
    chk("bp_idle", idle, 1);
    // credit limit on unit 1
    valid_in = 1;
    sel_in = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cr_ready", ready_in, 1);
      tick;
    end
    #1 chk("cr_full_ready", ready_in, 0);
    chk("cr_full_valid", unit_req_valid, 0);
    chk("cr_full_cnt", dut.cnt[1], 4);
    chk("cr_not_idle", idle, 0);
    valid_in = 0;
    unit_rsp_valid = 5'b00010;
    #1 chk("cr_pop", unit_rsp_ready, 5'b00010);
    tick;
    unit_rsp_valid = 0;
    chk("cr_pop_valid", valid_out, 1);
    chk("cr_pop_unit", unit_out, 1);
    chk("cr_pop_cnt", dut.cnt[1], 3);
    valid_in = 1;
    #1 chk("cr_reopen", ready_in, 1);
    chk("cr_reopen_valid", unit_req_valid, 5'b00010);
    tick;
    valid_in = 0;
    chk("cr_refill_cnt", dut.cnt[1], 4);
    sel_in = 0;
    unit_req_ready = 5'b11110;
    #1 chk("unit_not_ready", ready_in, 0);
    unit_req_ready = '1;
    // out-of-range select
    valid_in = 1;
    sel_in = 7;
    #1 chk("oor_ready", ready_in, 1);
    chk("oor_valid", unit_req_valid, 0);
    tick;
    valid_in = 0;
    chk("oor_err", sel_err, 1);
    chk("oor_cnt1", dut.cnt[1], 4);
    chk("oor_cnt0", dut.cnt[0], 0);
    tick;
    chk("oor_err_clear", sel_err, 0);
    // simultaneous inc/dec on unit 0
    valid_in = 1;
    sel_in = 0;
    tick; tick;
    chk("incdec_pre", dut.cnt[0], 2);
    unit_rsp_valid = 5'b00001;
    #1 chk("incdec_pop", unit_rsp_ready, 5'b00001);
    tick;
    unit_rsp_valid = 0;
    chk("incdec_cnt", dut.cnt[0], 2);
    chk("incdec_valid", valid_out, 1);
    ready_out = 0;
    tick;
    valid_in = 0;
    chk("pre_rst_cnt", dut.cnt[0], 3);
    chk("pre_rst_valid", valid_out, 1);
    // reset mid-operation
    reset = 1;
    tick;
    reset = 0;
    chk("mid_rst_cnt0", dut.cnt[0], 0);
    chk("mid_rst_cnt1", dut.cnt[1], 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_idle", idle, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
